// File: rtl/fifo_wr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter_pkg
//   Shared definitions for the fifo write-port arbiter.
//   - arb_state_e : arbiter FSM encoding (ARB_IDLE=0, ARB_GRANT=1)
//   - clog2_min1  : ceil(log2(n)), never less than 1, used to size ID fields
// ----------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // An ID field needs at least one bit, even when $clog2 returns 0.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin search. Starting one past last_i and wrapping
//   modulo NUM_REQ, returns the first set bit of req_i.
//   Ports:
//     req_i   in   NUM_REQ   request vector
//     last_i  in   ID_WIDTH  index granted last time (lowest search priority)
//     found_o out  1         at least one request is set
//     idx_o   out  ID_WIDTH  winning index (0 when nothing is found)
// ----------------------------------------------------------------------------
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [ID_WIDTH-1:0] last_i,
    output logic                found_o,
    output logic [ID_WIDTH-1:0] idx_o
);

    int cand;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the unassigned paths infer latches.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        // k = NUM_REQ lands back on last_i, so the previous winner is tried last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_i) + k) % NUM_REQ;
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = ID_WIDTH'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing one fifo write port between NUM_REQ
//   requesters. A grant lasts for up to MAX_BURST beats; beats pass through a
//   one-entry registered output slot tagged with the source index.
//   Ports:
//     clkIn        in   1                   clock, rising edge
//     rstIn        in   1                   synchronous active-high reset
//     reqDataIn    in   NUM_REQ*DATA_WIDTH  requester i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//     reqValidIn   in   NUM_REQ             per-requester valid
//     reqReadyOut  out  NUM_REQ             per-requester ready, at most one bit set
//     wrDataOut    out  DATA_WIDTH          registered payload to fifo
//     wrIdOut      out  ID_WIDTH            source index of wrDataOut
//     wrValidOut   out  1                   registered valid to fifo
//     wrReadyIn    in   1                   fifo ready
//     grantOut     out  NUM_REQ             one-hot current grant, 0 when idle
// ----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = 8,
    localparam int ID_WIDTH   = clog2_min1(NUM_REQ)
) (
    input  logic                          clkIn,
    input  logic                          rstIn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataIn,
    input  logic [NUM_REQ-1:0]            reqValidIn,
    output logic [NUM_REQ-1:0]            reqReadyOut,
    output logic [DATA_WIDTH-1:0]         wrDataOut,
    output logic [ID_WIDTH-1:0]           wrIdOut,
    output logic                          wrValidOut,
    input  logic                          wrReadyIn,
    output logic [NUM_REQ-1:0]            grantOut
);

    localparam int                     BURST_WIDTH = $clog2(MAX_BURST + 1);
    localparam logic [BURST_WIDTH-1:0] LAST_BEAT   = BURST_WIDTH'(MAX_BURST - 1);
    localparam logic [ID_WIDTH-1:0]    RESET_LAST  = ID_WIDTH'(NUM_REQ - 1);

    arb_state_e              state_q, state_d;
    // last_q doubles as the current grant index while in ARB_GRANT.
    logic [ID_WIDTH-1:0]     last_q, last_d;
    logic [BURST_WIDTH-1:0]  beat_q, beat_d;
    logic                    wr_valid_q, wr_valid_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [ID_WIDTH-1:0]     wr_id_q, wr_id_d;

    logic                    pick_found;
    logic [ID_WIDTH-1:0]     pick_idx;
    logic                    granted;
    logic                    slot_free;
    logic                    grant_valid;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   grant_data;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .req_i   (reqValidIn),
        .last_i  (last_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign granted     = (state_q == ARB_GRANT);
    // The slot can take a beat when empty or when it drains on this edge.
    assign slot_free   = !wr_valid_q || wrReadyIn;
    assign grant_valid = reqValidIn[last_q];
    assign grant_data  = reqDataIn[int'(last_q)*DATA_WIDTH +: DATA_WIDTH];
    assign accept      = granted && grant_valid && slot_free;

    // Ready is the only combinational input-to-output path (via wrReadyIn).
    always_comb begin : ready_decode
        reqReadyOut = '0;
        grantOut    = '0;
        if (granted) begin
            reqReadyOut[last_q] = slot_free;
            grantOut[last_q]    = 1'b1;
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        last_d  = last_q;
        beat_d  = beat_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    last_d  = pick_idx;
                    beat_d  = '0;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (accept) begin
                    beat_d = beat_q + BURST_WIDTH'(1);
                end
                // Release on a full burst or as soon as the owner drops valid.
                if (!grant_valid || (accept && beat_q == LAST_BEAT)) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin : slot_next
        wr_valid_d = wr_valid_q;
        wr_data_d  = wr_data_q;
        wr_id_d    = wr_id_q;
        if (accept) begin
            // Covers drain-and-refill on the same edge: valid stays high.
            wr_valid_d = 1'b1;
            wr_data_d  = grant_data;
            wr_id_d    = last_q;
        end else if (wrReadyIn) begin
            wr_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block ordering.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state_q    <= ARB_IDLE;
            last_q     <= RESET_LAST;
            beat_q     <= '0;
            wr_valid_q <= 1'b0;
            // NOTE: payload registers are normally left unreset; these are
            // reset because wrDataOut/wrIdOut have defined values after reset.
            wr_data_q  <= '0;
            wr_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            beat_q     <= beat_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
            wr_id_q    <= wr_id_d;
        end
    end

    assign wrValidOut = wr_valid_q;
    assign wrDataOut  = wr_data_q;
    assign wrIdOut    = wr_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter: 4 queue-driven requesters, a fifo
//   model (DEPTH 256, ready while fewer than DEPTH-SKID entries) and a per-ID
//   ordered scoreboard of every beat written into the fifo.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
    import fifo_wr_arbiter_pkg::*;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int MAX_BURST  = 8;
    localparam int ID_WIDTH   = 2;
    localparam int DEPTH      = 256;
    localparam int SKID       = 32;
    localparam int FILL_LIMIT = DEPTH - SKID;

    logic                          clkIn;
    logic                          rstIn;
    logic [NUM_REQ*DATA_WIDTH-1:0] reqDataIn;
    logic [NUM_REQ-1:0]            reqValidIn;
    logic [NUM_REQ-1:0]            reqReadyOut;
    logic [DATA_WIDTH-1:0]         wrDataOut;
    logic [ID_WIDTH-1:0]           wrIdOut;
    logic                          wrValidOut;
    logic                          wrReadyIn;
    logic [NUM_REQ-1:0]            grantOut;

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clkIn       (clkIn),
        .rstIn       (rstIn),
        .reqDataIn   (reqDataIn),
        .reqValidIn  (reqValidIn),
        .reqReadyOut (reqReadyOut),
        .wrDataOut   (wrDataOut),
        .wrIdOut     (wrIdOut),
        .wrValidOut  (wrValidOut),
        .wrReadyIn   (wrReadyIn),
        .grantOut    (grantOut)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    logic [DATA_WIDTH-1:0] req_q [NUM_REQ][$];
    logic [DATA_WIDTH-1:0] exp_q [NUM_REQ][$];
    logic [DATA_WIDTH-1:0] fifo_q[$];
    int acc_id[$];
    int acc_cyc[$];
    int cyc;
    int base;
    int n_vec;
    int n_err;
    logic rd_en;
    logic stall;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            reqValidIn[i] = (req_q[i].size() > 0);
            reqDataIn[i*DATA_WIDTH +: DATA_WIDTH] = (req_q[i].size() > 0) ? req_q[i][0] : '0;
        end
        wrReadyIn = !stall && (fifo_q.size() < FILL_LIMIT);
    endtask

    task automatic push_req(input int i, input logic [DATA_WIDTH-1:0] v);
        req_q[i].push_back(v);
        exp_q[i].push_back(v);
    endtask

    task automatic flush_all();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_q[i].delete();
            exp_q[i].delete();
        end
        fifo_q.delete();
    endtask

    task automatic clear_logs();
        acc_id.delete();
        acc_cyc.delete();
        base = cyc;
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NUM_REQ; i++) s += req_q[i].size();
        return s;
    endfunction

    // One clock: sample handshakes before the edge, update models after it,
    // then drive the next inputs.
    task automatic tick();
        logic [NUM_REQ-1:0]    fire;
        logic                  wr_fire, rd_fire, in_rst, hold;
        logic [DATA_WIDTH-1:0] wdata;
        logic [ID_WIDTH-1:0]   wid;
        fire    = reqValidIn & reqReadyOut;
        wr_fire = wrValidOut && wrReadyIn;
        rd_fire = rd_en && (fifo_q.size() > 0);
        in_rst  = rstIn;
        hold    = wrValidOut && !wrReadyIn;
        wdata   = wrDataOut;
        wid     = wrIdOut;
        check("grant_onehot0", 64'($onehot0(grantOut)), 64'd1);
        check("ready_onehot0", 64'($onehot0(reqReadyOut)), 64'd1);
        @(posedge clkIn);
        cyc++;
        if (!in_rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fire[i]) begin
                    void'(req_q[i].pop_front());
                    acc_id.push_back(i);
                    acc_cyc.push_back(cyc);
                end
            end
            if (wr_fire) begin
                fifo_q.push_back(wdata);
                if (exp_q[wid].size() == 0) check("sb_extra_beat", 64'(wid) + 64'h100, 64'(wid));
                else check("sb_data", 64'(wdata), 64'(exp_q[wid].pop_front()));
            end
            if (rd_fire) void'(fifo_q.pop_front());
        end
        #1;
        if (!in_rst && hold) begin
            check("hold_valid", 64'(wrValidOut), 64'd1);
            check("hold_data", 64'(wrDataOut), 64'(wdata));
            check("hold_id", 64'(wrIdOut), 64'(wid));
        end
        drive();
        #1;
    endtask

    task automatic do_reset();
        flush_all();
        rstIn = 1'b1;
        drive();
        repeat (2) tick();
        rstIn = 1'b0;
        drive();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; base = 0;
        rd_en = 1'b1; stall = 1'b0;
        rstIn = 1'b1; reqValidIn = '0; reqDataIn = '0; wrReadyIn = 1'b0;
        #2;

        // 1: single requester, 20 beats -> bursts 8, 8, 4 with idle gaps
        do_reset();
        check("rst_valid", 64'(wrValidOut), 64'd0);
        check("rst_grant", 64'(grantOut), 64'd0);
        check("rst_ready", 64'(reqReadyOut), 64'd0);
        clear_logs();
        for (int k = 1; k <= 20; k++) push_req(0, DATA_WIDTH'(k));
        drive(); #1;
        repeat (30) tick();
        check("s1_beats", 64'(acc_id.size()), 64'd20);
        for (int j = 0; j < acc_id.size(); j++) begin
            check("s1_id", 64'(acc_id[j]), 64'd0);
            check("s1_cycle", 64'(acc_cyc[j]), 64'(base + 2 + (j / 8) * 9 + j % 8));
        end
        check("s1_drained", 64'(exp_q[0].size()), 64'd0);

        // 2: all four valid, 8 beats each -> grants 0,1,2,3 in runs of 8
        do_reset();
        clear_logs();
        for (int i = 0; i < NUM_REQ; i++)
            for (int k = 0; k < 8; k++) push_req(i, DATA_WIDTH'(((i + 1) << 8) | k));
        drive(); #1;
        repeat (45) tick();
        check("s2_beats", 64'(acc_id.size()), 64'd32);
        for (int m = 0; m < acc_id.size(); m++) begin
            check("s2_id", 64'(acc_id[m]), 64'(m / 8));
            check("s2_cycle", 64'(acc_cyc[m]), 64'(base + 2 + (m / 8) * 9 + m % 8));
        end

        // 3: fifo stalls for 5 cycles mid-burst
        clear_logs();
        for (int k = 0; k < 8; k++) push_req(1, DATA_WIDTH'(32'h3000 + k));
        drive(); #1;
        repeat (4) tick();
        stall = 1'b1;
        drive(); #1;
        for (int s = 0; s < 6; s++) begin
            check("s3_ready", 64'(reqReadyOut), 64'd0);
            check("s3_valid", 64'(wrValidOut), 64'd1);
            check("s3_data", 64'(wrDataOut), 64'h3002);
            if (s < 5) tick();
        end
        stall = 1'b0;
        drive(); #1;
        repeat (20) tick();
        check("s3_req_left", 64'(req_q[1].size()), 64'd0);
        check("s3_lost", 64'(exp_q[1].size()), 64'd0);

        // 4: requester 2 drops after 3 beats; 0 and 3 pending -> 3 wins next
        clear_logs();
        for (int k = 0; k < 3; k++) push_req(2, DATA_WIDTH'(32'h4200 + k));
        for (int k = 0; k < 2; k++) push_req(0, DATA_WIDTH'(32'h4000 + k));
        for (int k = 0; k < 2; k++) push_req(3, DATA_WIDTH'(32'h4300 + k));
        drive(); #1;
        repeat (20) tick();
        check("s4_beats", 64'(acc_id.size()), 64'd7);
        begin
            int exp_ids[7] = '{2, 2, 2, 3, 3, 0, 0};
            for (int j = 0; j < 7 && j < acc_id.size(); j++)
                check("s4_id", 64'(acc_id[j]), 64'(exp_ids[j]));
        end
        if (acc_cyc.size() > 3) check("s4_regrant_cycle", 64'(acc_cyc[3]), 64'(base + 7));

        // 5: one-cycle reset mid-burst with the output slot full
        clear_logs();
        for (int k = 0; k < 8; k++) push_req(1, DATA_WIDTH'(32'h5100 + k));
        drive(); #1;
        repeat (4) tick();
        check("s5_pre_valid", 64'(wrValidOut), 64'd1);
        rstIn = 1'b1;
        drive(); #1;
        tick();
        rstIn = 1'b0;
        #1;
        check("s5_valid", 64'(wrValidOut), 64'd0);
        check("s5_data", 64'(wrDataOut), 64'd0);
        check("s5_id", 64'(wrIdOut), 64'd0);
        check("s5_grant", 64'(grantOut), 64'd0);
        check("s5_ready", 64'(reqReadyOut), 64'd0);
        flush_all();
        clear_logs();
        for (int k = 0; k < 2; k++) begin
            push_req(0, DATA_WIDTH'(32'h5000 + k));
            push_req(1, DATA_WIDTH'(32'h5110 + k));
        end
        drive(); #1;
        repeat (12) tick();
        check("s5_beats", 64'(acc_id.size()), 64'd4);
        if (acc_id.size() > 0) check("s5_first_grant", 64'(acc_id[0]), 64'd0);

        // 6: fill the fifo to its skid threshold, drain one, resume
        flush_all();
        clear_logs();
        rd_en = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            for (int k = 0; k < 58; k++) push_req(i, DATA_WIDTH'(32'h6000 | (i << 8) | k));
        drive(); #1;
        repeat (300) tick();
        check("s6_fill", 64'(fifo_q.size()), 64'(FILL_LIMIT));
        check("s6_slot_full", 64'(wrValidOut), 64'd1);
        check("s6_wr_ready", 64'(wrReadyIn), 64'd0);
        check("s6_stalled", 64'(reqReadyOut), 64'd0);
        check("s6_pending", 64'(pending()), 64'd7);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        drive(); #1;
        repeat (3) tick();
        check("s6_refill", 64'(fifo_q.size()), 64'(FILL_LIMIT));
        check("s6_resumed", 64'(pending()), 64'd6);
        rd_en = 1'b1;
        drive(); #1;
        repeat (300) tick();
        check("s6_pending_end", 64'(pending()), 64'd0);
        for (int i = 0; i < NUM_REQ; i++) check("s6_lost", 64'(exp_q[i].size()), 64'd0);
        check("s6_fifo_empty", 64'(fifo_q.size()), 64'd0);
        check("s6_idle_valid", 64'(wrValidOut), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
